iobuf_turnaround_bank: RTL and testbench
========================================

// Module: iobuf_turnaround_bank
// PURPOSE
//  - Parametrised bank of WIDTH bidirectional pad buffers with registered output data,
//    registered tristate control and registered input capture (IOB-style flops).
//  - Inserts TURN_CYC guaranteed hi-Z cycles on every direction change, so two drivers
//    never fight on a shared bidirectional bus.
//  - Sits between core logic and shared bidirectional pins. Replaces per-bit
//    combinational tristate buffers that have no timing or turnaround control.
// PARAMETERS
//  WIDTH     8  number of pad bits in the bank
//  TURN_CYC  1  hi-Z dead cycles on each direction change; legal range 0..15
// PORTS
//  CLK     in     1      bank clock; all flops are rising-edge
//  RST_N   in     1      asynchronous reset, active-low
//  I       in     WIDTH  core data to drive onto the pads
//  T_REQ   in     1      direction request: 1 = receive (hi-Z), 0 = transmit (drive)
//  IO      inout  WIDTH  pads
//  O       out    WIDTH  registered pad capture
//  O_VLD   out    1      O holds a sample taken while the bank was settled in RX
//  T_ACT   out    1      actual tristate state: 1 = pads hi-Z, 0 = pads driven
//  BUSY    out    1      turnaround in progress (TURN_TX or TURN_RX)
// BEHAVIOUR
//  - Reset (RST_N=0, async), all values held until the first edge after release:
//      state=RX, T_ACT=1, BUSY=0, O=0, O_VLD=0, output data reg=0, turnaround count=0.
//  - Output path: I is registered on every edge, in all states.
//      IO = T_ACT ? {WIDTH{1'bz}} : data_reg.
//      Latency from I to pad is 1 cycle while in TX.
//  - Input path: O <= IO on every edge. O_VLD <= (state==RX).
//      O and O_VLD are pipelined identically.
//  - States: RX, TURN_TX, TX, TURN_RX. T_ACT=0 only in TX. BUSY=1 only in TURN_*.
//  - RX, T_REQ=0 sampled at edge k:
//      TURN_CYC=0 -> TX at edge k; pads driven after edge k.
//      otherwise  -> TURN_TX with count loaded; TX entered at edge k+TURN_CYC.
//  - TURN_TX: count decrements each edge; at 0 go to TX.
//      T_REQ=1 during TURN_TX aborts to RX on the next edge; pads never driven.
//  - TX, T_REQ=1 sampled at edge k:
//      pads hi-Z after edge k (T_ACT registered with the state).
//      TURN_RX for TURN_CYC cycles, then RX; TURN_CYC=0 goes directly to RX.
//  - TURN_RX, T_REQ=0: go to TURN_TX and reload the full count. Pads stay hi-Z;
//      TX is entered TURN_CYC cycles after that edge.
//  - Steady T_REQ holds the current RX or TX state indefinitely. No other transitions.
//  - The count register is 4 bits wide. TURN_CYC > 15 is illegal; the implementation
//    must fire an elaboration-time $error.
//  - Mid-operation reset: the bank returns to RX and hi-Z immediately (async). No drive
//    glitch is permitted.
// CONFIGURATION
//  - IOBUF_TURNAROUND_IN_SYNC_EN defined:
//      adds two synchroniser flop stages ahead of the O capture, for asynchronous pads.
//      O and O_VLD latency becomes 3 cycles.
//      The O_VLD pipeline is lengthened to match; all stages reset to 0.
//  - Not defined: single capture stage, 1-cycle latency, as above.
// TESTING
//  1. Reset: assert RST_N=0 mid-TX with I=8'hA5 -> pads hi-Z at once; T_ACT=1, O=0,
//     O_VLD=0, BUSY=0.
//  2. RX->TX, TURN_CYC=2: T_REQ 1->0 at edge k -> BUSY=1 for 2 cycles; T_ACT=0 after
//     edge k+2; with I=8'h3C held, IO=8'h3C from then on.
//  3. TX->RX, TURN_CYC=2: T_REQ 0->1 at edge k -> IO hi-Z after edge k. External drive
//     8'h5A -> O=8'h5A; O_VLD=1 from edge k+3 (k+5 with IN_SYNC_EN).
//  4. Abort: in TURN_TX, T_REQ back to 1 -> RX next edge; T_ACT stays 1 throughout
//     (checker: pads never driven).
//  5. TURN_CYC=0: toggle T_REQ every cycle -> T_ACT follows T_REQ one edge later;
//     BUSY always 0.
//  6. TURN_RX re-request: T_REQ=0 one cycle into TURN_RX -> TURN_TX; pads driven exactly
//     TURN_CYC edges later, with no drive overlap against an external driver model.

Source files
------------

// File: rtl/iobuf_turnaround_bank.sv
// iobuf_turnaround_bank
//   Bank of WIDTH bidirectional pad buffers with IOB-style registered output data,
//   registered tristate control and registered input capture. Every direction change
//   passes through TURN_CYC guaranteed hi-Z cycles, so this bank and a far-end driver
//   never fight on a shared bus.
//
//   Parameters
//     WIDTH     number of pad bits
//     TURN_CYC  hi-Z dead cycles per direction change, 0..15
//
//   Ports
//     clk     bank clock, rising edge
//     rst_n   asynchronous reset, active low (bank goes to RX / hi-Z at once)
//     i       core data to drive onto the pads (registered every edge)
//     t_req   direction request: 1 = receive (hi-Z), 0 = transmit
//     io      pads
//     o       registered pad capture
//     o_vld   o holds a sample taken while the bank was settled in RX
//     t_act   actual tristate state: 1 = pads hi-Z, 0 = pads driven
//     busy    turnaround in progress
//
//   Optional build macro
//     IOBUF_TURNAROUND_IN_SYNC_EN  two synchroniser stages ahead of the o capture
//                                  (o / o_vld latency 3 cycles instead of 1)
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_RX      | receiving, pads hi-Z, settled
//   ST_TURN_TX | dead cycles before driving, pads hi-Z
//   ST_TX      | driving the pads from the output data register
//   ST_TURN_RX | dead cycles after driving, pads hi-Z

module iobuf_turnaround_bank #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic             t_req,
  inout  wire  [WIDTH-1:0] io,
  output logic [WIDTH-1:0] o,
  output logic             o_vld,
  output logic             t_act,
  output logic             busy
);

  if (TURN_CYC > 15 || TURN_CYC < 0) begin : g_turn_cyc_range
    $error("iobuf_turnaround_bank: TURN_CYC=%0d outside 0..15", TURN_CYC);
  end

  localparam logic [1:0] ST_RX      = 2'd0;
  localparam logic [1:0] ST_TURN_TX = 2'd1;
  localparam logic [1:0] ST_TX      = 2'd2;
  localparam logic [1:0] ST_TURN_RX = 2'd3;

  // The count runs TURN_CYC-1 .. 0, so a turnaround state lasts exactly TURN_CYC cycles.
  localparam logic [3:0] CNT_LOAD = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);
  localparam bit         NO_TURN  = (TURN_CYC == 0);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RX: begin
        if (!t_req) begin
          if (NO_TURN) begin
            state_d = ST_TX;
          end else begin
            state_d = ST_TURN_TX;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_TURN_TX: begin
        if (t_req) begin
          state_d = ST_RX;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_TX;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_TX: begin
        if (t_req) begin
          if (NO_TURN) begin
            state_d = ST_RX;
          end else begin
            state_d = ST_TURN_RX;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_TURN_RX: begin
        // A transmit request mid-turnaround restarts the full dead time toward TX,
        // because the far end may already have started driving.
        if (!t_req) begin
          state_d = ST_TURN_TX;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RX;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_RX;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // t_act and busy are decoded from the next state so they are clean flop outputs
  // that change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RX;
      cnt_q   <= 4'd0;
      t_act   <= 1'b1;
      busy    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_act   <= (state_d != ST_TX);
      busy    <= (state_d == ST_TURN_TX) || (state_d == ST_TURN_RX);
      data_q  <= i;
    end
  end

  assign io = t_act ? {WIDTH{1'bz}} : data_q;

`ifdef IOBUF_TURNAROUND_IN_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [1:0]       vld_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      vld_pipe_q <= 2'b00;
      o          <= '0;
      o_vld      <= 1'b0;
    end else begin
      sync1_q    <= io;
      sync2_q    <= sync1_q;
      vld_pipe_q <= {vld_pipe_q[0], (state_q == ST_RX)};
      o          <= sync2_q;
      o_vld      <= vld_pipe_q[1];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o     <= '0;
      o_vld <= 1'b0;
    end else begin
      o     <= io;
      o_vld <= (state_q == ST_RX);
    end
  end
`endif

endmodule

// File: tb/tb_iobuf_turnaround_bank.sv
// tb_iobuf_turnaround_bank
//   Directed bench for iobuf_turnaround_bank. dut2 uses TURN_CYC=2 and shares its pad
//   bus with an external driver model; dut0 uses TURN_CYC=0.

module tb_iobuf_turnaround_bank;

`ifdef IOBUF_TURNAROUND_IN_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] i2, i0, ext_val;
  logic       t_req2, t_req0, ext_en;
  wire  [7:0] io2, io0;
  logic [7:0] o2, o0;
  logic       o_vld2, o_vld0, t_act2, t_act0, busy2, busy0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign io2 = ext_en ? ext_val : 8'hzz;

  iobuf_turnaround_bank #(.WIDTH(8), .TURN_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i(i2), .t_req(t_req2), .io(io2),
    .o(o2), .o_vld(o_vld2), .t_act(t_act2), .busy(busy2)
  );

  iobuf_turnaround_bank #(.WIDTH(8), .TURN_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i(i0), .t_req(t_req0), .io(io0),
    .o(o0), .o_vld(o_vld0), .t_act(t_act0), .busy(busy0)
  );

  // Bus contention monitor: the far end must never see our pads driven while it drives.
  always @(negedge clk) begin
    if (rst_n && ext_en) begin
      n_vec++;
      if (t_act2 == 1'b0) begin
        n_err++;
        $display("FAIL overlap t=%0t: t_act=%0b while external driver active (required 1)", $time, t_act2);
      end
    end
  end

  typedef struct {
    logic       t_req;
    logic [7:0] din;
    logic       ext_en;
    logic [7:0] ext_val;
    logic       exp_t_act;
    logic       exp_busy;
    logic [7:0] exp_pad;
  } vec_t;

  vec_t vec [22];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  initial begin
    //          t_req din    ext  ext_val t_act busy pad
    vec[0]  = '{1'b1, 8'h11, 1'b1, 8'h5A, 1'b1, 1'b0, 8'h00};
    vec[1]  = '{1'b0, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vec[2]  = '{1'b0, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vec[3]  = '{1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C};
    vec[4]  = '{1'b0, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0, 8'hC3};
    vec[5]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vec[6]  = '{1'b1, 8'hFF, 1'b1, 8'hA6, 1'b1, 1'b1, 8'h00};
    vec[7]  = '{1'b1, 8'hFF, 1'b1, 8'hA7, 1'b1, 1'b0, 8'h00};
    vec[8]  = '{1'b0, 8'h12, 1'b1, 8'hA8, 1'b1, 1'b1, 8'h00};
    vec[9]  = '{1'b1, 8'h12, 1'b1, 8'hA9, 1'b1, 1'b0, 8'h00};
    vec[10] = '{1'b1, 8'h12, 1'b1, 8'hAA, 1'b1, 1'b0, 8'h00};
    vec[11] = '{1'b0, 8'h34, 1'b1, 8'hAB, 1'b1, 1'b1, 8'h00};
    vec[12] = '{1'b0, 8'h34, 1'b1, 8'hAC, 1'b1, 1'b1, 8'h00};
    vec[13] = '{1'b0, 8'h96, 1'b0, 8'h00, 1'b0, 1'b0, 8'h96};
    vec[14] = '{1'b1, 8'h96, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vec[15] = '{1'b0, 8'h77, 1'b1, 8'h5B, 1'b1, 1'b1, 8'h00};
    vec[16] = '{1'b0, 8'h77, 1'b1, 8'h5C, 1'b1, 1'b1, 8'h00};
    vec[17] = '{1'b0, 8'h5E, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5E};
    vec[18] = '{1'b0, 8'h5E, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5E};
    vec[19] = '{1'b1, 8'h5E, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vec[20] = '{1'b1, 8'h5E, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00};
    vec[21] = '{1'b1, 8'h5E, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

    rst_n = 1'b0; t_req2 = 1'b1; t_req0 = 1'b1; i2 = 8'h00; i0 = 8'h00;
    ext_en = 1'b0; ext_val = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_t_act", {7'd0, t_act2}, 8'h01);
    chk("reset_busy",  {7'd0, busy2},  8'h00);
    chk("reset_o",     o2,             8'h00);
    chk("reset_o_vld", {7'd0, o_vld2}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: FSM sequencing on dut2 (turnarounds, abort, TURN_RX re-request).
    for (int k = 0; k < 22; k++) begin
      t_req2  = vec[k].t_req;
      i2      = vec[k].din;
      ext_en  = vec[k].ext_en;
      ext_val = vec[k].ext_val;
      @(posedge clk);
      #1;
      n_vec++;
      if (t_act2 !== vec[k].exp_t_act || busy2 !== vec[k].exp_busy ||
          (vec[k].exp_t_act == 1'b0 && io2 !== vec[k].exp_pad)) begin
        n_err++;
        $display("FAIL vec%0d: t_act=%0b busy=%0b pad=%h, required t_act=%0b busy=%0b pad=%h",
                 k, t_act2, busy2, io2, vec[k].exp_t_act, vec[k].exp_busy, vec[k].exp_pad);
      end
    end

    // TX -> RX capture: external 5A appears on o after LAT edges, o_vld from edge k+2+LAT.
    t_req2 = 1'b0; ext_en = 1'b0; i2 = 8'h3C;
    repeat (6) @(posedge clk);
    #1;
    chk("seqA_tx_t_act", {7'd0, t_act2}, 8'h00);
    chk("seqA_tx_pad",   io2,            8'h3C);
    t_req2 = 1'b1;
    @(posedge clk);
    #1;
    chk("seqA_hiz_after_k", {7'd0, t_act2}, 8'h01);
    ext_en = 1'b1; ext_val = 8'h5A;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
      chk($sformatf("seqA_o_vld_k+%0d", n), {7'd0, o_vld2}, (n >= 2 + LAT) ? 8'h01 : 8'h00);
      if (n >= LAT) chk($sformatf("seqA_o_k+%0d", n), o2, 8'h5A);
    end

    // Mid-TX asynchronous reset.
    @(negedge clk);
    ext_en = 1'b0; t_req2 = 1'b0; i2 = 8'hA5;
    repeat (4) @(posedge clk);
    #1;
    chk("seqB_tx_t_act", {7'd0, t_act2}, 8'h00);
    chk("seqB_tx_pad",   io2,            8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("seqB_rst_t_act", {7'd0, t_act2}, 8'h01);
    chk("seqB_rst_busy",  {7'd0, busy2},  8'h00);
    chk("seqB_rst_o",     o2,             8'h00);
    chk("seqB_rst_o_vld", {7'd0, o_vld2}, 8'h00);
    chk("seqB_rst_o0",    o0,             8'h00);
    chk("seqB_rst_vld0",  {7'd0, o_vld0}, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("seqB_rst_hold_t_act", {7'd0, t_act2}, 8'h01);
    @(negedge clk);
    t_req2 = 1'b1;
    rst_n = 1'b1;

    // TURN_CYC=0: t_act follows t_req one edge later, never busy.
    for (int n = 0; n < 10; n++) begin
      t_req0 = n[0];
      i0     = 8'(n * 17 + 3);
      @(posedge clk);
      #1;
      chk($sformatf("seqC_t_act_%0d", n), {7'd0, t_act0}, {7'd0, t_req0});
      chk($sformatf("seqC_busy_%0d", n),  {7'd0, busy0},  8'h00);
      if (!t_req0) chk($sformatf("seqC_pad_%0d", n), io0, i0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
